// File: rtl/executa_movimentos_pkg.sv
// ============================================================================
// Module  : executa_movimentos_pkg
// Purpose : State codes, face codes and move-word layout shared by the move
//           executor and the serial receive stage that fills the move RAM.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package executa_movimentos_pkg;

    typedef enum logic [3:0] {
        ST_INICIAL      = 4'h0,
        ST_PREPARA      = 4'h1,
        ST_LE_MEM       = 4'h2,
        ST_DECODIFICA   = 4'h3,
        ST_ACIONA       = 4'h4,
        ST_ESPERA_MOTOR = 4'h5,
        ST_ASSENTA      = 4'h6,
        ST_ATUALIZA     = 4'h7,
        ST_FINAL        = 4'h8,
        ST_ERRO         = 4'hF
    } estado_t;

    typedef enum logic [2:0] {
        FACE_U       = 3'd0,
        FACE_D       = 3'd1,
        FACE_F       = 3'd2,
        FACE_B       = 3'd3,
        FACE_L       = 3'd4,
        FACE_R       = 3'd5,
        FACE_INVALID = 3'd6,
        FACE_FIM     = 3'd7
    } face_t;

    // Move word: [3:1] face code, [0] direction (1 = counter-clockwise)
    localparam int C_FACE_MSB    = 3;
    localparam int C_FACE_LSB    = 1;
    localparam int C_SENTIDO_BIT = 0;

    function automatic logic [2:0] campo_face(input logic [3:0] palavra);
        return palavra[C_FACE_MSB:C_FACE_LSB];
    endfunction

endpackage

`default_nettype wire

// File: rtl/executa_movimentos_if.sv
// ============================================================================
// Module  : executa_movimentos_if
// Purpose : Move RAM read port plus motor driver start/done handshake.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface executa_movimentos_if #(
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [3:0]            mem_dado;
    logic                  partida_motor;
    logic [2:0]            face;
    logic                  sentido;
    logic                  fim_motor;

    modport master (
        output mem_addr, partida_motor, face, sentido,
        input  mem_dado, fim_motor
    );

    modport slave (
        input  mem_addr, partida_motor, face, sentido,
        output mem_dado, fim_motor
    );
endinterface

`default_nettype wire

// File: rtl/contador_m.sv
// ============================================================================
// Module  : contador_m
// Purpose : Generic modulo-M counter with synchronous clear and enable; fim
//           is high while the count sits at M-1.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module contador_m #(
    parameter int M = 16
) (
    input  wire logic clock,
    input  wire logic reset,
    input  wire logic zera,
    input  wire logic conta,
    output logic      fim
);
    localparam int N = (M > 1) ? $clog2(M) : 1;

    logic [N-1:0] r_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_q <= '0;
        end else if (zera) begin
            r_q <= '0;
        end else if (conta) begin
            r_q <= fim ? '0 : r_q + N'(1);
        end
    end

    assign fim = (r_q == N'(M - 1));
endmodule

`default_nettype wire

// File: rtl/executa_movimentos_fd.sv
// ============================================================================
// Module  : executa_movimentos_fd
// Purpose : Datapath: RAM address, latched face/direction, completed-move
//           count, timeout and settle counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module executa_movimentos_fd
    import executa_movimentos_pkg::*;
#(
    parameter int ADDR_WIDTH     = 5,
    parameter int SETTLE_CYCLES  = 50000,
    parameter int TIMEOUT_CYCLES = 5000000
) (
    input  wire logic                  clock,
    input  wire logic                  reset,
    input  wire logic [3:0]            mem_dado,
    input  wire logic                  zera_addr,
    input  wire logic                  incrementa_addr,
    input  wire logic                  zera_exec,
    input  wire logic                  conta_exec,
    input  wire logic                  carrega_face,
    input  wire logic                  zera_timeout,
    input  wire logic                  conta_timeout,
    input  wire logic                  zera_settle,
    input  wire logic                  conta_settle,
    output logic [ADDR_WIDTH-1:0]      mem_addr,
    output logic [2:0]                 face,
    output logic                       sentido,
    output logic [ADDR_WIDTH:0]        num_exec,
    output logic                       addr_ultimo,
    output logic                       fim_timeout,
    output logic                       fim_settle
);
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [2:0]            r_face;
    logic                  r_sentido;
    logic [ADDR_WIDTH:0]   r_num_exec;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_mem_addr <= '0;
            r_num_exec <= '0;
        end else begin
            if (zera_addr) begin
                r_mem_addr <= '0;
            end else if (incrementa_addr) begin
                r_mem_addr <= r_mem_addr + ADDR_WIDTH'(1);
            end
            if (zera_exec) begin
                r_num_exec <= '0;
            end else if (conta_exec) begin
                r_num_exec <= r_num_exec + (ADDR_WIDTH + 1)'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_face    <= '0;
            r_sentido <= 1'b0;
        end else if (carrega_face) begin
            r_face    <= campo_face(mem_dado);
            r_sentido <= mem_dado[C_SENTIDO_BIT];
        end
    end

    contador_m #(.M(TIMEOUT_CYCLES)) u_timeout (
        .clock (clock),
        .reset (reset),
        .zera  (zera_timeout),
        .conta (conta_timeout),
        .fim   (fim_timeout)
    );

    contador_m #(.M(SETTLE_CYCLES)) u_settle (
        .clock (clock),
        .reset (reset),
        .zera  (zera_settle),
        .conta (conta_settle),
        .fim   (fim_settle)
    );

    assign mem_addr    = r_mem_addr;
    assign face        = r_face;
    assign sentido     = r_sentido;
    assign num_exec    = r_num_exec;
    assign addr_ultimo = (r_mem_addr == {ADDR_WIDTH{1'b1}});
endmodule

`default_nettype wire

// File: rtl/executa_movimentos_uc.sv
// ============================================================================
// Module  : executa_movimentos_uc
// Purpose : Control FSM sequencing read, decode, motor handshake, settle and
//           advance over the move list.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module executa_movimentos_uc
    import executa_movimentos_pkg::*;
(
    input  wire logic       clock,
    input  wire logic       reset,
    input  wire logic       iniciar,
    input  wire logic       fim_motor,
    input  wire logic [2:0] face_lida,
    input  wire logic       addr_ultimo,
    input  wire logic       fim_timeout,
    input  wire logic       fim_settle,
    output logic            zera_addr,
    output logic            incrementa_addr,
    output logic            zera_exec,
    output logic            conta_exec,
    output logic            carrega_face,
    output logic            zera_timeout,
    output logic            conta_timeout,
    output logic            zera_settle,
    output logic            conta_settle,
    output logic            partida_motor,
    output logic            ocupado,
    output logic            pronto,
    output logic            erro,
    output estado_t         estado
);
    estado_t r_estado;
    estado_t w_proximo;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado <= ST_INICIAL;
        end else begin
            r_estado <= w_proximo;
        end
    end

    always_comb begin
        w_proximo       = r_estado;
        zera_addr       = 1'b0;
        incrementa_addr = 1'b0;
        zera_exec       = 1'b0;
        conta_exec      = 1'b0;
        carrega_face    = 1'b0;
        zera_timeout    = 1'b0;
        conta_timeout   = 1'b0;
        zera_settle     = 1'b0;
        conta_settle    = 1'b0;
        case (r_estado)
            ST_INICIAL: begin
                if (iniciar) w_proximo = ST_PREPARA;
            end
            ST_PREPARA: begin
                zera_addr = 1'b1;
                zera_exec = 1'b1;
                w_proximo = ST_LE_MEM;
            end
            ST_LE_MEM: begin
                w_proximo = ST_DECODIFICA;
            end
            ST_DECODIFICA: begin
                // Timeout window is measured from the partida cycle itself
                zera_timeout = 1'b1;
                if (face_lida == FACE_FIM) begin
                    w_proximo = ST_FINAL;
                end else if (face_lida == FACE_INVALID) begin
                    w_proximo = ST_ERRO;
                end else begin
                    carrega_face = 1'b1;
                    w_proximo    = ST_ACIONA;
                end
            end
            ST_ACIONA: begin
                conta_timeout = 1'b1;
                w_proximo     = ST_ESPERA_MOTOR;
            end
            ST_ESPERA_MOTOR: begin
                conta_timeout = 1'b1;
                zera_settle   = 1'b1;
                if (fim_motor) begin
                    w_proximo = ST_ASSENTA;
                end else if (fim_timeout) begin
                    w_proximo = ST_ERRO;
                end
            end
            ST_ASSENTA: begin
                conta_settle = 1'b1;
                if (fim_settle) w_proximo = ST_ATUALIZA;
            end
            ST_ATUALIZA: begin
                conta_exec = 1'b1;
                if (addr_ultimo) begin
                    w_proximo = ST_FINAL;
                end else begin
                    incrementa_addr = 1'b1;
                    w_proximo       = ST_LE_MEM;
                end
            end
            ST_FINAL: begin
                w_proximo = ST_INICIAL;
            end
            ST_ERRO: begin
                if (iniciar) w_proximo = ST_PREPARA;
            end
            default: begin
                w_proximo = ST_INICIAL;
            end
        endcase
    end

    assign partida_motor = (r_estado == ST_ACIONA);
    assign pronto        = (r_estado == ST_FINAL);
    assign erro          = (r_estado == ST_ERRO);
    assign ocupado       = (r_estado != ST_INICIAL) && (r_estado != ST_FINAL) &&
                           (r_estado != ST_ERRO);
    assign estado        = r_estado;
endmodule

`default_nettype wire

// File: rtl/executa_movimentos.sv
// ============================================================================
// Module  : executa_movimentos
// Purpose : Reads the stored move list in address order and drives the
//           motor driver one move at a time; pulses pronto when done.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module executa_movimentos
    import executa_movimentos_pkg::*;
#(
    parameter int ADDR_WIDTH     = 5,
    parameter int SETTLE_CYCLES  = 50000,
    parameter int TIMEOUT_CYCLES = 5000000
) (
    input  wire logic             clock,
    input  wire logic             reset,
    input  wire logic             iniciar,
    executa_movimentos_if.master  bus,
    output logic                  ocupado,
    output logic                  pronto,
    output logic                  erro,
    output logic [ADDR_WIDTH:0]   db_num_exec,
    output logic [3:0]            db_estado
);
    logic    w_zera_addr;
    logic    w_incrementa_addr;
    logic    w_zera_exec;
    logic    w_conta_exec;
    logic    w_carrega_face;
    logic    w_zera_timeout;
    logic    w_conta_timeout;
    logic    w_zera_settle;
    logic    w_conta_settle;
    logic    w_addr_ultimo;
    logic    w_fim_timeout;
    logic    w_fim_settle;
    estado_t w_estado;

    executa_movimentos_uc u_uc (
        .clock           (clock),
        .reset           (reset),
        .iniciar         (iniciar),
        .fim_motor       (bus.fim_motor),
        .face_lida       (campo_face(bus.mem_dado)),
        .addr_ultimo     (w_addr_ultimo),
        .fim_timeout     (w_fim_timeout),
        .fim_settle      (w_fim_settle),
        .zera_addr       (w_zera_addr),
        .incrementa_addr (w_incrementa_addr),
        .zera_exec       (w_zera_exec),
        .conta_exec      (w_conta_exec),
        .carrega_face    (w_carrega_face),
        .zera_timeout    (w_zera_timeout),
        .conta_timeout   (w_conta_timeout),
        .zera_settle     (w_zera_settle),
        .conta_settle    (w_conta_settle),
        .partida_motor   (bus.partida_motor),
        .ocupado         (ocupado),
        .pronto          (pronto),
        .erro            (erro),
        .estado          (w_estado)
    );

    executa_movimentos_fd #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .SETTLE_CYCLES  (SETTLE_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_fd (
        .clock           (clock),
        .reset           (reset),
        .mem_dado        (bus.mem_dado),
        .zera_addr       (w_zera_addr),
        .incrementa_addr (w_incrementa_addr),
        .zera_exec       (w_zera_exec),
        .conta_exec      (w_conta_exec),
        .carrega_face    (w_carrega_face),
        .zera_timeout    (w_zera_timeout),
        .conta_timeout   (w_conta_timeout),
        .zera_settle     (w_zera_settle),
        .conta_settle    (w_conta_settle),
        .mem_addr        (bus.mem_addr),
        .face            (bus.face),
        .sentido         (bus.sentido),
        .num_exec        (db_num_exec),
        .addr_ultimo     (w_addr_ultimo),
        .fim_timeout     (w_fim_timeout),
        .fim_settle      (w_fim_settle)
    );

    assign db_estado = w_estado;
endmodule

`default_nettype wire
